// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, captures same-cycle memory data into a DEPTH-entry prefetch FIFO.
// One edge from im_addr to out_valid; when the FIFO is full without a pop, fetch_pc stalls; a redirect flushes.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        addr_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int           AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]  CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          addr_err_q, addr_err_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic empty, full, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign pop   = out_valid & out_ready;
  // A pop frees a slot in the same edge, so a full FIFO can still stream.
  assign push  = ~redirect_valid & (~full | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_err_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= im_instr;
    end
  end

  assign im_addr      = fetch_pc_q;
  assign addr_err     = addr_err_q;
  assign out_valid    = ~empty;
  assign out_pc       = empty ? 32'h0 : pc_mem_q[rd_ptr_q];
  assign out_instr    = empty ? 32'h0 : instr_mem_q[rd_ptr_q];
  assign out_pc_plus4 = empty ? 32'h0 : pc_mem_q[rd_ptr_q] + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: expected PCs are queued per scenario and retired on each accepted head entry.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        addr_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'hC3A5_0000;
  endfunction

  assign im_instr = mem_word(im_addr);

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_instr(im_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .addr_err(addr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    checks++; if (im_addr !== 32'h0) $display("FAIL reset_im_addr got %h exp %h", im_addr, 32'h0); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", out_pc); else passes++;
    checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", out_instr); else passes++;
    checks++; if (out_pc_plus4 !== 32'h0) $display("FAIL reset_pc_plus4 got %h exp 0", out_pc_plus4); else passes++;
    checks++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err got %b exp 0", addr_err); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", out_valid); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL first_pc got %h exp 0", out_pc); else passes++;
    checks++; if (out_instr !== mem_word(32'h0)) $display("FAIL first_instr got %h exp %h", out_instr, mem_word(32'h0)); else passes++;
    checks++; if (im_addr !== 32'h4) $display("FAIL first_im_addr got %h exp 4", im_addr); else passes++;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    out_ready = 1'b1;
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    for (int i = 0; i < 6; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid cyc %0d got %b exp 1", i, out_valid); else passes++;
      checks++; if (out_pc !== e) $display("FAIL stream_pc got %h exp %h", out_pc, e); else passes++;
      checks++; if (out_instr !== mem_word(e)) $display("FAIL stream_instr got %h exp %h", out_instr, mem_word(e)); else passes++;
      checks++; if (out_pc_plus4 !== e + 32'd4) $display("FAIL stream_pc_plus4 got %h exp %h", out_pc_plus4, e + 32'd4); else passes++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL wrap_bubble got %b exp 0", out_valid); else passes++;
    exp_q = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1) $display("FAIL wrap_valid cyc %0d got %b exp 1", i, out_valid); else passes++;
      checks++; if (out_pc !== e) $display("FAIL wrap_pc got %h exp %h", out_pc, e); else passes++;
      checks++; if (out_pc_plus4 !== e + 32'd4) $display("FAIL wrap_pc_plus4 got %h exp %h", out_pc_plus4, e + 32'd4); else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    tick();
    checks++; if (im_addr !== 32'h4) $display("FAIL bp_im_addr1 got %h exp 4", im_addr); else passes++;
    tick();
    checks++; if (im_addr !== 32'h8) $display("FAIL bp_im_addr2 got %h exp 8", im_addr); else passes++;
    tick();
    checks++; if (im_addr !== 32'h8) $display("FAIL bp_im_addr_hold got %h exp 8", im_addr); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL bp_pc_hold got %h exp 0", out_pc); else passes++;
    checks++; if (out_instr !== mem_word(32'h0)) $display("FAIL bp_instr_hold got %h exp %h", out_instr, mem_word(32'h0)); else passes++;
    out_ready = 1'b1;
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid cyc %0d got %b exp 1", i, out_valid); else passes++;
      checks++; if (out_pc !== e) $display("FAIL bp_drain_pc got %h exp %h", out_pc, e); else passes++;
      checks++; if (out_instr !== mem_word(e)) $display("FAIL bp_drain_instr got %h exp %h", out_instr, mem_word(e)); else passes++;
      tick();
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] e;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rd_bubble got %b exp 0", out_valid); else passes++;
    checks++; if (addr_err !== 1'b0) $display("FAIL rd_addr_err got %b exp 0", addr_err); else passes++;
    checks++; if (im_addr !== 32'h20) $display("FAIL rd_im_addr got %h exp 20", im_addr); else passes++;
    tick();
    out_ready = 1'b1;
    exp_q = {32'h20, 32'h24, 32'h28};
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1) $display("FAIL rd_valid cyc %0d got %b exp 1", i, out_valid); else passes++;
      checks++; if (out_pc !== e) $display("FAIL rd_pc got %h exp %h", out_pc, e); else passes++;
      checks++; if (out_instr !== mem_word(e)) $display("FAIL rd_instr got %h exp %h", out_instr, mem_word(e)); else passes++;
      tick();
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    tick();
    redirect_valid = 1'b0;
    checks++; if (addr_err !== 1'b1) $display("FAIL mis_addr_err got %b exp 1", addr_err); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL mis_bubble got %b exp 0", out_valid); else passes++;
    checks++; if (im_addr !== 32'h20) $display("FAIL mis_im_addr got %h exp 20", im_addr); else passes++;
    tick();
    checks++; if (addr_err !== 1'b0) $display("FAIL mis_addr_err_clear got %b exp 0", addr_err); else passes++;
    checks++; if (out_pc !== 32'h20) $display("FAIL mis_pc got %h exp 20", out_pc); else passes++;
    checks++; if (out_valid !== 1'b1) $display("FAIL mis_valid got %b exp 1", out_valid); else passes++;
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_bubble got %b exp 0", out_valid); else passes++;
    checks++; if (im_addr !== 32'h200) $display("FAIL b2b_im_addr got %h exp 200", im_addr); else passes++;
    tick();
    checks++; if (out_pc !== 32'h200) $display("FAIL b2b_pc got %h exp 200", out_pc); else passes++;
    checks++; if (out_instr !== mem_word(32'h200)) $display("FAIL b2b_instr got %h exp %h", out_instr, mem_word(32'h200)); else passes++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL ar_pre_valid got %b exp 1", out_valid); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL ar_valid got %b exp 0", out_valid); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL ar_pc got %h exp 0", out_pc); else passes++;
    checks++; if (out_pc_plus4 !== 32'h0) $display("FAIL ar_pc_plus4 got %h exp 0", out_pc_plus4); else passes++;
    checks++; if (im_addr !== 32'h0) $display("FAIL ar_im_addr got %h exp 0", im_addr); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h0) $display("FAIL ar_restart_pc got %h exp 0", out_pc); else passes++;
    checks++; if (out_instr !== mem_word(32'h0)) $display("FAIL ar_restart_instr got %h exp %h", out_instr, mem_word(32'h0)); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
